// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one 16-bit memory port between two requesters. Accesses
//            run one at a time through IDLE -> ACCESS -> RESP with a fixed
//            read latency. Ties are broken round-robin, and each completion
//            is signalled with a one-cycle ack pulse.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic        we0,
  input  logic        we1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic [1:0]  gnt,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_RESP   = 2'd2;
  localparam logic [3:0] c_LAT    = 4'(LATENCY);

  logic [1:0]  r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_last, w_last_nxt;
  logic        r_is_rd, w_is_rd_nxt;
  logic [1:0]  r_gnt, w_gnt_nxt;
  logic        r_ack0, w_ack0_nxt;
  logic        r_ack1, w_ack1_nxt;
  logic        r_mem_we, w_we_nxt;
  logic [15:0] r_mem_addr, w_addr_nxt;
  logic [15:0] r_mem_wdata, w_wdata_nxt;
  logic [15:0] r_rdata, w_rdata_nxt;
  logic        w_any;
  logic        w_pick;
  logic        w_done;

  // Arbitration: a lone request wins; on a tie the port that did not go last wins.
  assign w_any  = req0 | req1;
  assign w_pick = (req0 & req1) ? ~r_last : req1;
  assign w_done = (r_cnt == 4'd1);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; requests only matter while idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (w_any)  w_state_nxt = c_ACCESS;
      c_ACCESS: if (w_done) w_state_nxt = c_RESP;
      c_RESP:   w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  // Next values for the registered outputs and bookkeeping.
  always_comb begin
    w_gnt_nxt   = r_gnt;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_rdata_nxt = r_rdata;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_is_rd_nxt = r_is_rd;
    w_we_nxt    = 1'b0;  // write strobe lives for the first ACCESS cycle only
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_any) begin
          w_gnt_nxt   = w_pick ? 2'b10 : 2'b01;
          w_addr_nxt  = w_pick ? addr1 : addr0;
          w_wdata_nxt = w_pick ? wdata1 : wdata0;
          w_we_nxt    = w_pick ? we1 : we0;
          w_is_rd_nxt = ~(w_pick ? we1 : we0);
          w_cnt_nxt   = c_LAT;
          w_last_nxt  = w_pick;
        end
      end
      c_ACCESS: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (w_done) begin
          w_ack0_nxt = r_gnt[0];
          w_ack1_nxt = r_gnt[1];
          if (r_is_rd) w_rdata_nxt = mem_rdata;
        end
      end
      default: begin
        w_gnt_nxt   = 2'b00;
        w_addr_nxt  = 16'h0000;
        w_wdata_nxt = 16'h0000;
      end
    endcase
  end

  // Output and bookkeeping registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt       <= 2'b00;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
      r_rdata     <= 16'h0000;
      r_cnt       <= 4'd0;
      r_last      <= 1'b1;
      r_is_rd     <= 1'b0;
    end else begin
      r_gnt       <= w_gnt_nxt;
      r_ack0      <= w_ack0_nxt;
      r_ack1      <= w_ack1_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last      <= w_last_nxt;
      r_is_rd     <= w_is_rd_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed, table-driven bench for mem_arbiter (LATENCY=1 and 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  gnt;

  logic        d4_req0;
  logic [15:0] d4_addr0, d4_mem_rdata;
  logic        d4_ack0, d4_ack1, d4_mem_we;
  logic [15:0] d4_rdata, d4_mem_addr, d4_mem_wdata;
  logic [1:0]  d4_gnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .gnt(gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .req0(d4_req0), .req1(1'b0), .addr0(d4_addr0), .addr1(16'h0000),
    .wdata0(16'h0000), .wdata1(16'h0000), .we0(1'b0), .we1(1'b0),
    .ack0(d4_ack0), .ack1(d4_ack1), .rdata(d4_rdata), .gnt(d4_gnt),
    .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata), .mem_we(d4_mem_we),
    .mem_rdata(d4_mem_rdata)
  );

  // Small memory behind the LATENCY=1 arbiter; contents reload while reset is high.
  logic [15:0] mem_model [0:255];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_model[i] <= 16'h0000;
      mem_model[8'h10] <= 16'hBEEF;
      mem_model[8'h30] <= 16'hCAFE;
    end else if (mem_we) begin
      mem_model[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_model[mem_addr[7:0]];

  typedef struct {
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  e_gnt;
    logic        e_ack0, e_ack1, e_we;
    logic [15:0] e_addr, e_wdata, e_rdata;
  } vec_t;

  vec_t tv [0:31];
  int   n_tv = 0;

  task automatic add(input logic r0, input logic r1, input logic [15:0] a0, input logic [15:0] a1,
                     input logic [15:0] d0, input logic [15:0] d1, input logic w0, input logic w1,
                     input logic [1:0] g, input logic k0, input logic k1, input logic [15:0] ea,
                     input logic [15:0] ed, input logic ew, input logic [15:0] er);
    tv[n_tv].req0 = r0;   tv[n_tv].req1 = r1;
    tv[n_tv].addr0 = a0;  tv[n_tv].addr1 = a1;
    tv[n_tv].wdata0 = d0; tv[n_tv].wdata1 = d1;
    tv[n_tv].we0 = w0;    tv[n_tv].we1 = w1;
    tv[n_tv].e_gnt = g;   tv[n_tv].e_ack0 = k0; tv[n_tv].e_ack1 = k1;
    tv[n_tv].e_addr = ea; tv[n_tv].e_wdata = ed; tv[n_tv].e_we = ew;
    tv[n_tv].e_rdata = er;
    n_tv++;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] prev_rd, new_rd;
    int port;
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    d4_req0 = 0; d4_addr0 = 0; d4_mem_rdata = 0;

    // Port 0 read of 0x0010 (BEEF).
    add(1,0,16'h0010,0,0,0,0,0, 2'b01,0,0,16'h0010,0,0,16'h0000);
    add(1,0,16'h0010,16'hFFFF,0,0,0,0, 2'b01,1,0,16'h0010,0,0,16'hBEEF);
    add(0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0,16'hBEEF);
    // Port 1 write of 0x1234 to 0x0020; rdata must hold.
    add(0,1,0,16'h0020,0,16'h1234,0,1, 2'b10,0,0,16'h0020,16'h1234,1,16'hBEEF);
    add(0,1,0,16'h0020,0,16'h1234,0,1, 2'b10,0,1,16'h0020,16'h1234,0,16'hBEEF);
    add(0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0,16'hBEEF);
    // Both ports requesting for six accesses: grants alternate starting with port 0.
    prev_rd = 16'hBEEF;
    for (int p = 0; p < 6; p++) begin
      port   = p % 2;
      new_rd = (port == 1) ? 16'h1234 : 16'hCAFE;
      add(1,1,16'h0030,16'h0020,16'h1111,16'h2222,0,0,
          (port == 1) ? 2'b10 : 2'b01, 0, 0,
          (port == 1) ? 16'h0020 : 16'h0030, (port == 1) ? 16'h2222 : 16'h1111, 0, prev_rd);
      add(1,1,16'h0030,16'h0020,16'h1111,16'h2222,0,0,
          (port == 1) ? 2'b10 : 2'b01, (port == 0), (port == 1),
          (port == 1) ? 16'h0020 : 16'h0030, (port == 1) ? 16'h2222 : 16'h1111, 0, new_rd);
      add((p != 5),(p != 5),16'h0030,16'h0020,16'h1111,16'h2222,0,0,
          2'b00,0,0,0,0,0,new_rd);
      prev_rd = new_rd;
    end
    add(0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0,16'h1234);

    // Reset values.
    repeat (3) step();
    chk("reset gnt", {14'd0, gnt}, 16'h0000);
    chk("reset ack0", {15'd0, ack0}, 16'h0000);
    chk("reset ack1", {15'd0, ack1}, 16'h0000);
    chk("reset mem_addr", mem_addr, 16'h0000);
    chk("reset mem_wdata", mem_wdata, 16'h0000);
    chk("reset mem_we", {15'd0, mem_we}, 16'h0000);
    chk("reset rdata", rdata, 16'h0000);
    reset = 1'b0;
    step();
    chk("post-reset idle gnt", {14'd0, gnt}, 16'h0000);
    chk("post-reset d4 gnt", {14'd0, d4_gnt}, 16'h0000);

    // Table-driven vectors.
    for (int i = 0; i < n_tv; i++) begin
      req0 = tv[i].req0;     req1 = tv[i].req1;
      addr0 = tv[i].addr0;   addr1 = tv[i].addr1;
      wdata0 = tv[i].wdata0; wdata1 = tv[i].wdata1;
      we0 = tv[i].we0;       we1 = tv[i].we1;
      step();
      chk($sformatf("row%0d gnt", i), {14'd0, gnt}, {14'd0, tv[i].e_gnt});
      chk($sformatf("row%0d ack0", i), {15'd0, ack0}, {15'd0, tv[i].e_ack0});
      chk($sformatf("row%0d ack1", i), {15'd0, ack1}, {15'd0, tv[i].e_ack1});
      chk($sformatf("row%0d mem_addr", i), mem_addr, tv[i].e_addr);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata, tv[i].e_wdata);
      chk($sformatf("row%0d mem_we", i), {15'd0, mem_we}, {15'd0, tv[i].e_we});
      chk($sformatf("row%0d rdata", i), rdata, tv[i].e_rdata);
    end

    // Reset during the first ACCESS cycle of a port 1 write.
    req1 = 1; addr1 = 16'h0050; wdata1 = 16'hABCD; we1 = 1;
    step();
    chk("rst-mid grant gnt", {14'd0, gnt}, 16'h0002);
    chk("rst-mid grant we", {15'd0, mem_we}, 16'h0001);
    #2 reset = 1'b1;
    #1;
    chk("rst-mid async we", {15'd0, mem_we}, 16'h0000);
    chk("rst-mid async gnt", {14'd0, gnt}, 16'h0000);
    chk("rst-mid async addr", mem_addr, 16'h0000);
    chk("rst-mid async wdata", mem_wdata, 16'h0000);
    chk("rst-mid async rdata", rdata, 16'h0000);
    req1 = 0; we1 = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("rst-mid hold ack1 %0d", i), {15'd0, ack1}, 16'h0000);
    end
    reset = 1'b0;
    req0 = 1; req1 = 1; addr0 = 16'h0010; addr1 = 16'h0020; we0 = 0; we1 = 0;
    step();
    chk("after-rst tie gnt", {14'd0, gnt}, 16'h0001);
    step();
    chk("after-rst ack0", {15'd0, ack0}, 16'h0001);
    chk("after-rst ack1", {15'd0, ack1}, 16'h0000);
    chk("after-rst rdata", rdata, 16'hBEEF);
    req0 = 0; req1 = 0;
    step();
    chk("after-rst idle gnt", {14'd0, gnt}, 16'h0000);

    // LATENCY=4 read: rdata must be the value present at the fourth edge.
    d4_req0 = 1; d4_addr0 = 16'h0077; d4_mem_rdata = 16'hA000;
    step();
    chk("lat4 grant gnt", {14'd0, d4_gnt}, 16'h0001);
    chk("lat4 grant addr", d4_mem_addr, 16'h0077);
    for (int i = 1; i <= 4; i++) begin
      d4_mem_rdata = 16'hA000 + 16'(i);
      step();
      chk($sformatf("lat4 edge%0d ack0", i), {15'd0, d4_ack0}, (i == 4) ? 16'h0001 : 16'h0000);
      chk($sformatf("lat4 edge%0d rdata", i), d4_rdata, (i == 4) ? 16'hA004 : 16'h0000);
    end
    d4_req0 = 0;
    step();
    chk("lat4 idle gnt", {14'd0, d4_gnt}, 16'h0000);
    chk("lat4 idle ack0", {15'd0, d4_ack0}, 16'h0000);
    chk("lat4 hold rdata", d4_rdata, 16'hA004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the CPU's single 16-bit memory port (address, write data, write enable, read data) between two requesters: port 0 (CPU control unit) and port 1 (loader/DMA). It sequences one access at a time through a fixed-latency IDLE → ACCESS → RESP state machine. Ties are resolved round-robin, and each completed access is acknowledged with a one-cycle pulse. It sits between the requesters and `mem`, replacing direct tri-state drive of the address/data buses.

## Interface
- `LATENCY`, default 1: memory read latency in clock edges from address valid to `mem_rdata` valid; legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state and outputs immediately.
- `req0`, `req1` input 1 each: access request; must be held high until the matching ack is seen.
- `addr0`, `addr1` input 16 each: request address.
- `wdata0`, `wdata1` input 16 each: request write data.
- `we0`, `we1` input 1 each: 1 = write, 0 = read.
- `ack0`, `ack1` output 1 each: one-cycle completion pulse.
- `rdata` output 16: registered read data from the most recent completed read.
- `gnt` output 2: one-hot current owner; 00 when idle.
- `mem_addr` output 16, `mem_wdata` output 16, `mem_we` output 1: drive to the memory.
- `mem_rdata` input 16: data from the memory.

## Operation
- Reset values: state IDLE; `gnt`=00; `ack0`/`ack1`=0; `mem_addr`=0; `mem_wdata`=0; `mem_we`=0; `rdata`=0; round-robin pointer `last`=1, so port 0 wins the first tie.
- **IDLE**: requests are sampled only in this state.
  - If exactly one req is high, grant it.
  - If both are high, grant the port ≠ `last`.
  - On grant: latch that port's addr/wdata/we into `mem_addr`/`mem_wdata`/`mem_we`, set `gnt`, load counter = `LATENCY`, set `last` = granted port, go to ACCESS.
- **ACCESS**:
  - `mem_we` is high only in the first ACCESS cycle; it clears at the next edge, so exactly one write strobe is issued per write.
  - Counter decrements each edge.
  - At the edge where counter == 1: go to RESP, assert the granted port's ack, and capture `mem_rdata` into `rdata` if the access was a read. `rdata` holds its value on writes.
- **RESP**: ack is high for this single cycle. At the next edge: ack clears, `gnt`=00, `mem_addr`/`mem_wdata`=0, go to IDLE.
- Requester rule: drop req at the edge where ack is sampled high. Because req is ignored in RESP, a req still held at IDLE is treated as a new request.
- Request inputs changing while not granted have no effect on the in-flight access; latched values are used throughout.
- Reset mid-access: the in-flight access is abandoned with no ack, `mem_we` drops asynchronously, and the FSM returns to IDLE.
- No starvation: with both ports continuously requesting, grants alternate 0,1,0,1,...

## Timing
- Grant edge k (req sampled in IDLE):
  - `mem_addr`/`gnt` are valid after edge k.
  - `mem_we` is high for cycle k..k+1 only.
  - ack and `rdata` are valid after edge k+`LATENCY`.
- Return to IDLE at edge k+`LATENCY`+1; the earliest next grant is at edge k+`LATENCY`+2.
- Throughput is one access per `LATENCY`+2 cycles (3 cycles at default).
- All outputs are registered; there are no combinational paths from req/addr inputs to memory outputs.

## Test plan
- **Reset**: assert `reset` asynchronously mid-cycle → all outputs 0 immediately; after release, idle with `gnt`=00.
- **Single read, `LATENCY`=1**: `mem_rdata`=16'hBEEF at address 16'h0010. Port 0 read of 16'h0010 at edge 0 → `mem_addr`=16'h0010 after edge 0, `ack0` high only after edge 1, `rdata`=16'hBEEF, `gnt` back to 00 after edge 2.
- **Single write, port 1**: addr 16'h0020, wdata 16'h1234 → `mem_we` high exactly one cycle with `mem_wdata`=16'h1234; `ack1` pulses once; `rdata` unchanged.
- **Both ports request continuously for 6 accesses** → grant order 0,1,0,1,0,1; each ack is a single-cycle pulse; the spacing between successive grants is 3 cycles.
- **`LATENCY`=4, port 0 read** → ack 4 edges after grant; `rdata` equals the `mem_rdata` value present at that edge, not earlier values.
- **Reset asserted during ACCESS of a port 1 write** → no `ack1`, `mem_we`=0 immediately; after release, a port 0 request is granted first (pointer reset to `last`=1).
